mandel_pixel_scheduler: RTL and testbench

Upstream sequencer for the Mandelbrot depth calculator. On a frame request it walks every pixel in raster order and incrementally derives the complex coordinate c for each pixel from a latched origin and step. It issues one start per pixel to the depth calculator, captures the returned depth, and forwards (x, y, depth) downstream on a valid/ready stream with line and frame markers. Exactly one calculator is kept in flight; there is no pipelining across pixels.

---
 rtl/mandel_pixel_scheduler_if.sv | 58 +++++
 rtl/mandel_pixel_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_mandel_pixel_scheduler.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mandel_pixel_scheduler_if.sv
// Bundle between the pixel scheduler, its frame controller, the depth calculator and the pixel sink.
// With MANDEL_CYCLE_COUNT_EN defined the bundle also carries the frame_cycles counter.
interface mandel_pixel_scheduler_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   frame_start;
    logic [WORD_LENGTH-1:0] re_origin;
    logic [WORD_LENGTH-1:0] im_origin;
    logic [WORD_LENGTH-1:0] step;
    logic [9:0]             max_iter_in;

    logic                   start;
    logic [9:0]             x;
    logic [8:0]             y;
    logic [WORD_LENGTH-1:0] re_c;
    logic [WORD_LENGTH-1:0] im_c;
    logic [9:0]             max_iter;
    logic                   calc_done;
    logic [9:0]             calc_depth;

    logic                   pix_valid;
    logic                   pix_ready;
    logic [9:0]             pix_x;
    logic [8:0]             pix_y;
    logic [9:0]             pix_depth;
    logic                   pix_eol;
    logic                   pix_sof;

    logic                   busy;
    logic                   frame_done;
`ifdef MANDEL_CYCLE_COUNT_EN
    logic [31:0]            frame_cycles;
`endif

    // Scheduler side
    modport master (
        input  frame_start, re_origin, im_origin, step, max_iter_in,
        input  calc_done, calc_depth, pix_ready,
        output start, x, y, re_c, im_c, max_iter,
        output pix_valid, pix_x, pix_y, pix_depth, pix_eol, pix_sof,
        output busy, frame_done
`ifdef MANDEL_CYCLE_COUNT_EN
        , output frame_cycles
`endif
    );

    // Environment side: frame controller, calculator and pixel sink
    modport slave (
        output frame_start, re_origin, im_origin, step, max_iter_in,
        output calc_done, calc_depth, pix_ready,
        input  start, x, y, re_c, im_c, max_iter,
        input  pix_valid, pix_x, pix_y, pix_depth, pix_eol, pix_sof,
        input  busy, frame_done
`ifdef MANDEL_CYCLE_COUNT_EN
        , input frame_cycles
`endif
    );
endinterface

// File: rtl/mandel_pixel_scheduler.sv
// Raster-order pixel sequencer feeding one Mandelbrot depth calculator and a valid/ready pixel stream.
// Optional MANDEL_CYCLE_COUNT_EN adds a saturating per-frame busy-cycle counter (frame_cycles).
module mandel_pixel_scheduler #(
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480
) (
    input  logic                     sysclk,
    input  logic                     reset,
    mandel_pixel_scheduler_if.master sched_bus
);

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

    if (FRAC >= WORD_LENGTH || H_RES < 1 || H_RES > 1024 || V_RES < 1 || V_RES > 512) begin : g_bad_config
        $error("mandel_pixel_scheduler: unsupported FRAC/H_RES/V_RES combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUTPUT,
        S_ADVANCE
    } state_t;

    state_t                 r_state,      w_state_next;
    logic [9:0]             r_x,          w_x_next;
    logic [8:0]             r_y,          w_y_next;
    logic [WORD_LENGTH-1:0] r_re_c,       w_re_c_next;
    logic [WORD_LENGTH-1:0] r_im_c,       w_im_c_next;
    logic [WORD_LENGTH-1:0] r_re_origin,  w_re_origin_next;
    logic [WORD_LENGTH-1:0] r_step,       w_step_next;
    logic [9:0]             r_max_iter,   w_max_iter_next;
    logic                   r_pix_valid,  w_pix_valid_next;
    logic [9:0]             r_pix_x,      w_pix_x_next;
    logic [8:0]             r_pix_y,      w_pix_y_next;
    logic [9:0]             r_pix_depth,  w_pix_depth_next;
    logic                   r_pix_eol,    w_pix_eol_next;
    logic                   r_pix_sof,    w_pix_sof_next;
    logic                   r_busy,       w_busy_next;
    logic                   r_frame_done, w_frame_done_next;
    logic                   r_done_q;
    logic                   w_calc_rise;
    logic                   w_accept;

    // calc_done idles high, so only a fresh rising edge marks this pixel's result.
    assign w_calc_rise = sched_bus.calc_done & ~r_done_q;
    assign w_accept    = (r_state == S_IDLE) & sched_bus.frame_start;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_re_c       <= '0;
            r_im_c       <= '0;
            r_re_origin  <= '0;
            r_step       <= '0;
            r_max_iter   <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_depth  <= '0;
            r_pix_eol    <= 1'b0;
            r_pix_sof    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_done_q     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_re_c       <= w_re_c_next;
            r_im_c       <= w_im_c_next;
            r_re_origin  <= w_re_origin_next;
            r_step       <= w_step_next;
            r_max_iter   <= w_max_iter_next;
            r_pix_valid  <= w_pix_valid_next;
            r_pix_x      <= w_pix_x_next;
            r_pix_y      <= w_pix_y_next;
            r_pix_depth  <= w_pix_depth_next;
            r_pix_eol    <= w_pix_eol_next;
            r_pix_sof    <= w_pix_sof_next;
            r_busy       <= w_busy_next;
            r_frame_done <= w_frame_done_next;
            r_done_q     <= sched_bus.calc_done;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_x_next          = r_x;
        w_y_next          = r_y;
        w_re_c_next       = r_re_c;
        w_im_c_next       = r_im_c;
        w_re_origin_next  = r_re_origin;
        w_step_next       = r_step;
        w_max_iter_next   = r_max_iter;
        w_pix_valid_next  = r_pix_valid;
        w_pix_x_next      = r_pix_x;
        w_pix_y_next      = r_pix_y;
        w_pix_depth_next  = r_pix_depth;
        w_pix_eol_next    = r_pix_eol;
        w_pix_sof_next    = r_pix_sof;
        w_busy_next       = r_busy;
        w_frame_done_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (sched_bus.frame_start) begin
                    w_re_origin_next = sched_bus.re_origin;
                    w_step_next      = sched_bus.step;
                    w_max_iter_next  = sched_bus.max_iter_in;
                    w_x_next         = '0;
                    w_y_next         = '0;
                    w_re_c_next      = sched_bus.re_origin;
                    w_im_c_next      = sched_bus.im_origin;
                    w_busy_next      = 1'b1;
                    w_state_next     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_state_next = S_WAIT;
            end

            S_WAIT: begin
                if (w_calc_rise) begin
                    w_pix_depth_next = sched_bus.calc_depth;
                    w_pix_x_next     = r_x;
                    w_pix_y_next     = r_y;
                    w_pix_eol_next   = (r_x == X_LAST);
                    w_pix_sof_next   = (r_x == '0) && (r_y == '0);
                    w_pix_valid_next = 1'b1;
                    w_state_next     = S_OUTPUT;
                end
            end

            S_OUTPUT: begin
                if (r_pix_valid && sched_bus.pix_ready) begin
                    w_pix_valid_next = 1'b0;
                    w_state_next     = S_ADVANCE;
                end
            end

            S_ADVANCE: begin
                // Coordinates move by pure add/sub; imaginary axis decreases going down the frame.
                if (r_x < X_LAST) begin
                    w_x_next     = r_x + 10'd1;
                    w_re_c_next  = r_re_c + r_step;
                    w_state_next = S_ISSUE;
                end else if (r_y < Y_LAST) begin
                    w_x_next     = '0;
                    w_y_next     = r_y + 9'd1;
                    w_re_c_next  = r_re_origin;
                    w_im_c_next  = r_im_c - r_step;
                    w_state_next = S_ISSUE;
                end else begin
                    w_busy_next       = 1'b0;
                    w_frame_done_next = 1'b1;
                    w_state_next      = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef MANDEL_CYCLE_COUNT_EN
    logic [31:0] r_frame_cycles;
    logic [31:0] w_frame_cycles_next;

    always_comb begin
        w_frame_cycles_next = r_frame_cycles;
        if (w_accept) begin
            w_frame_cycles_next = '0;
        end else if (r_busy && (r_frame_cycles != 32'hFFFF_FFFF)) begin
            w_frame_cycles_next = r_frame_cycles + 32'd1;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_frame_cycles <= '0;
        end else begin
            r_frame_cycles <= w_frame_cycles_next;
        end
    end

    assign sched_bus.frame_cycles = r_frame_cycles;
`else
    logic w_accept_unused;
    assign w_accept_unused = w_accept;
`endif

    assign sched_bus.start      = (r_state == S_ISSUE);
    assign sched_bus.x          = r_x;
    assign sched_bus.y          = r_y;
    assign sched_bus.re_c       = r_re_c;
    assign sched_bus.im_c       = r_im_c;
    assign sched_bus.max_iter   = r_max_iter;
    assign sched_bus.pix_valid  = r_pix_valid;
    assign sched_bus.pix_x      = r_pix_x;
    assign sched_bus.pix_y      = r_pix_y;
    assign sched_bus.pix_depth  = r_pix_depth;
    assign sched_bus.pix_eol    = r_pix_eol;
    assign sched_bus.pix_sof    = r_pix_sof;
    assign sched_bus.busy       = r_busy;
    assign sched_bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Directed bench for mandel_pixel_scheduler on a 4x2 frame with a 5-cycle calculator model.
module tb_mandel_pixel_scheduler;
    localparam int WL = 32;
    localparam int H  = 4;
    localparam int V  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mandel_pixel_scheduler_if #(.WORD_LENGTH(WL)) bus ();

    mandel_pixel_scheduler #(
        .WORD_LENGTH(WL),
        .FRAC       (28),
        .H_RES      (H),
        .V_RES      (V)
    ) dut (
        .sysclk   (clk),
        .reset    (rst),
        .sched_bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int cyc = 0, n_start = 0, n_pix = 0, n_fd = 0, n_busy = 0;
    logic [31:0] st_re [64];
    logic [31:0] st_im [64];
    int st_x [64], st_y [64], st_cyc [64];
    int px_x [64], px_y [64], px_depth [64], px_eol [64], px_sof [64];

    // Calculator model: done idles high, drops m_hold cycles after start, rises m_lat cycles after start.
    int m_hold = 0;
    int m_lat  = 5;
    int m_cnt  = 0;
    logic [9:0] m_depth = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt          <= 0;
            bus.calc_done  <= 1'b1;
            bus.calc_depth <= '0;
        end else if (bus.start) begin
            m_cnt   <= 1;
            m_depth <= bus.x + 10'(bus.y);
            if (m_hold == 0) bus.calc_done <= 1'b0;
        end else if (m_cnt != 0) begin
            if (m_cnt == m_hold) bus.calc_done <= 1'b0;
            if (m_cnt == m_lat) begin
                bus.calc_done  <= 1'b1;
                bus.calc_depth <= m_depth;
                m_cnt          <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (bus.busy) n_busy++;
        if (bus.start && n_start < 64) begin
            st_x[n_start]   = int'(bus.x);
            st_y[n_start]   = int'(bus.y);
            st_re[n_start]  = bus.re_c;
            st_im[n_start]  = bus.im_c;
            st_cyc[n_start] = cyc;
            $display("start   #%0d x=%0d y=%0d re_c=%08h im_c=%08h", n_start, bus.x, bus.y, bus.re_c, bus.im_c);
            n_start++;
        end
        if (bus.pix_valid && bus.pix_ready && n_pix < 64) begin
            px_x[n_pix]     = int'(bus.pix_x);
            px_y[n_pix]     = int'(bus.pix_y);
            px_depth[n_pix] = int'(bus.pix_depth);
            px_eol[n_pix]   = int'(bus.pix_eol);
            px_sof[n_pix]   = int'(bus.pix_sof);
            $display("pixel   #%0d x=%0d y=%0d depth=%0d eol=%0b sof=%0b", n_pix, bus.pix_x, bus.pix_y,
                     bus.pix_depth, bus.pix_eol, bus.pix_sof);
            n_pix++;
        end
        if (bus.frame_done) begin
            n_fd++;
            $display("frame_done #%0d at cycle %0d", n_fd, cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pulse_frame_start();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_frame_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start_xy(input int wx, input int wy, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (bus.start && int'(bus.x) == wx && int'(bus.y) == wy) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic set_frame(input logic [31:0] re_o, input logic [31:0] im_o, input logic [31:0] stp,
                             input logic [9:0] mi);
        bus.re_origin   = re_o;
        bus.im_origin   = im_o;
        bus.step        = stp;
        bus.max_iter_in = mi;
    endtask

    int bs, bp, bf, bb, snap_p, snap_f, snap_s, stable_err;
    logic [9:0] sx, sdepth;
    logic [8:0] sy;
    bit seen_valid;

    initial begin
        bus.frame_start = 1'b0;
        bus.pix_ready   = 1'b1;
        set_frame(32'h0, 32'h0, 32'h0, 10'd0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(bus.start), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_x", 32'(bus.x), 32'd0);
        chk("rst_re_c", bus.re_c, 32'd0);
        chk("rst_max_iter", 32'(bus.max_iter), 32'd0);
        chk("rst_pix_depth", 32'(bus.pix_depth), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1: basic raster walk, with an ignored re-request mid-frame
        set_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 10'd100);
        bs = n_start; bp = n_pix; bf = n_fd; bb = n_busy;
        pulse_frame_start();
        wait_start_xy(3, 0, "f1_reach_3_0");
        set_frame(32'h1234_5678, 32'h0, 32'h1, 10'd7);
        pulse_frame_start();
        wait_frame_done("f1_frame_done_seen");
        chk("f1_starts", 32'(n_start - bs), 32'd8);
        chk("f1_pixels", 32'(n_pix - bp), 32'd8);
        chk("f1_frame_done_cnt", 32'(n_fd - bf), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("f1_px%0d_x", i), 32'(px_x[bp+i]), 32'(i % H));
            chk($sformatf("f1_px%0d_y", i), 32'(px_y[bp+i]), 32'(i / H));
            chk($sformatf("f1_px%0d_depth", i), 32'(px_depth[bp+i]), 32'((i % H) + (i / H)));
            chk($sformatf("f1_px%0d_eol", i), 32'(px_eol[bp+i]), 32'((i % H) == 3));
            chk($sformatf("f1_px%0d_sof", i), 32'(px_sof[bp+i]), 32'(i == 0));
        end
        chk("f1_re_c_1_0", st_re[bs+1], 32'hE800_0000);
        chk("f1_re_c_3_0", st_re[bs+3], 32'hF800_0000);
        chk("f1_re_c_0_1", st_re[bs+4], 32'hE000_0000);
        chk("f1_im_c_0_1", st_im[bs+4], 32'h0800_0000);
        chk("f1_im_c_3_1", st_im[bs+7], 32'h0800_0000);
        chk("f1_max_iter", 32'(bus.max_iter), 32'd100);
        chk("f1_pixel_period", 32'(st_cyc[bs+1] - st_cyc[bs]), 32'd9);
        chk("f1_busy_cycles", 32'(n_busy - bb), 32'd72);
        chk("f1_busy_after", 32'(bus.busy), 32'd0);
`ifdef MANDEL_CYCLE_COUNT_EN
        chk("f1_frame_cycles", bus.frame_cycles, 32'd72);
`endif

        // Frame 2: done held high after start, plus a 10-cycle stall at pixel (2,1)
        m_hold = 2;
        set_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 10'd50);
        bs = n_start; bp = n_pix; bf = n_fd;
        pulse_frame_start();
        wait_start_xy(2, 1, "f2_reach_2_1");
        bus.pix_ready = 1'b0;
        seen_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.pix_valid) begin
                seen_valid = 1'b1;
                break;
            end
        end
        chk("f2_valid_seen", 32'(seen_valid), 32'd1);
        sx = bus.pix_x; sy = bus.pix_y; sdepth = bus.pix_depth;
        snap_s = n_start; stable_err = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!bus.pix_valid || bus.pix_x !== sx || bus.pix_y !== sy || bus.pix_depth !== sdepth
                || bus.pix_eol !== 1'b0 || bus.pix_sof !== 1'b0) stable_err++;
        end
        chk("f2_stall_pix_x", 32'(sx), 32'd2);
        chk("f2_stall_pix_y", 32'(sy), 32'd1);
        chk("f2_stall_depth", 32'(sdepth), 32'd3);
        chk("f2_stall_stable", 32'(stable_err), 32'd0);
        chk("f2_stall_no_start", 32'(n_start - snap_s), 32'd0);
        bus.pix_ready = 1'b1;
        wait_frame_done("f2_frame_done_seen");
        chk("f2_starts", 32'(n_start - bs), 32'd8);
        chk("f2_pixels", 32'(n_pix - bp), 32'd8);
        chk("f2_frame_done_cnt", 32'(n_fd - bf), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("f2_px%0d_depth", i), 32'(px_depth[bp+i]), 32'((i % H) + (i / H)));
        end
        chk("f2_max_iter", 32'(bus.max_iter), 32'd50);

        // Frame 3: reset while waiting on pixel (1,0), then restart
        m_hold = 0;
        bs = n_start; bp = n_pix; bf = n_fd;
        pulse_frame_start();
        wait_start_xy(1, 0, "f3_reach_1_0");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("f3_rst_busy", 32'(bus.busy), 32'd0);
        chk("f3_rst_start", 32'(bus.start), 32'd0);
        chk("f3_rst_x", 32'(bus.x), 32'd0);
        chk("f3_rst_re_c", bus.re_c, 32'd0);
        chk("f3_rst_im_c", bus.im_c, 32'd0);
        chk("f3_rst_max_iter", 32'(bus.max_iter), 32'd0);
        chk("f3_rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        snap_p = n_pix; snap_f = n_fd;
        chk("f3_pixels_before_rst", 32'(snap_p - bp), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("f3_no_pixel_after_rst", 32'(n_pix - snap_p), 32'd0);
        chk("f3_no_frame_done", 32'(n_fd - snap_f), 32'd0);
        bs = n_start; bp = n_pix; bf = n_fd;
        pulse_frame_start();
        wait_frame_done("f3_frame_done_seen");
        chk("f3_restart_x", 32'(st_x[bs]), 32'd0);
        chk("f3_restart_y", 32'(st_y[bs]), 32'd0);
        chk("f3_restart_re_c", st_re[bs], 32'hE000_0000);
        chk("f3_restart_im_c", st_im[bs], 32'h1000_0000);
        chk("f3_pixels", 32'(n_pix - bp), 32'd8);
        chk("f3_frame_done_cnt", 32'(n_fd - bf), 32'd1);

        // Frame 4: wrap-around arithmetic
        set_frame(32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, 10'd3);
        bs = n_start;
        pulse_frame_start();
        wait_frame_done("f4_frame_done_seen");
        chk("f4_re_c_1_0", st_re[bs+1], 32'hFFFF_FFFE);
        chk("f4_re_c_2_0", st_re[bs+2], 32'h7FFF_FFFD);
        chk("f4_im_c_0_1", st_im[bs+4], 32'h8000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
